gerador_borda: RTL and testbench
================================

# gerador_borda

Multi-channel pulse generator: the transmit-side counterpart of the team's edge detector. Each channel turns a single-cycle request strobe into a clean output pulse of programmable high time followed by a guaranteed minimum low time. One request can be queued per channel while a pulse is in flight. Used wherever a downstream edge detector or external pin must see well-formed, spaced rising edges.

## Interface
- CANAIS, 2, number of independent channels
- LARGURA_W, 8, width of the high/low duration fields and of the per-channel counters

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  CANAIS  per-channel request strobe, sampled each rising edge; one cycle high = one pulse requested
- alto  input  LARGURA_W  high duration in cycles, shared by all channels; 0 treated as 1
- baixo  input  LARGURA_W  minimum low duration after each pulse, in cycles; 0 = no gap
- saida  output  CANAIS  registered pulse outputs
- ocupado  output  CANAIS  channel not idle or has a queued request
- erro  output  CANAIS  sticky overflow flag: request dropped

## Operation
- Per channel, independent FSM: IDLE, HIGH, LOW; counter cnt (LARGURA_W bits); pending bit pend; latched duration baixo_l.
- Reset: state IDLE, cnt 0, pend 0, saida 0, erro 0, ocupado 0.
- saida = 1 exactly when state is HIGH (registered, no combinational path from req).
- ocupado = (state != IDLE) | pend.
- IDLE: start if req or pend -> HIGH, cnt = max(alto,1) - 1, baixo_l = baixo; pend cleared (set again if req also high while pend was the start source).
- HIGH: cnt != 0 -> decrement. cnt == 0 -> if baixo_l != 0 go LOW with cnt = baixo_l - 1; else if pend or req go HIGH again (new load, pend consumed); else IDLE.
- LOW: cnt != 0 -> decrement. cnt == 0 -> if pend or req go HIGH (new load); else IDLE.
- alto/baixo are sampled only at pulse start; changes mid-pulse do not affect the pulse in flight.
- req while not starting a pulse: if pend == 0, set pend; if pend == 1 and pend not consumed this cycle, request dropped and erro set.
- req on the same edge pend is consumed: pend stays 1 (new request queued), no error.
- erro is sticky; cleared only by rst.
- Arithmetic: unsigned, LARGURA_W bits, no wrap (counter only loads and decrements toward 0).
- rst mid-pulse: saida drops immediately (asynchronous), pending requests discarded.

## Timing
- Latency: req high at edge k -> saida high after edge k.
- Pulse width: exactly max(alto,1) cycles; saida falls after edge k + max(alto,1).
- Minimum period between rising edges of saida on one channel: max(alto,1) + baixo cycles.
- Back-to-back (baixo = 0): saida stays high continuously across queued pulses; no low cycle inserted.
- Channels never interact; simultaneous req on all channels start all pulses on the same edge.

## Configuration
- GERADOR_RETRIGGER_EN defined: req during HIGH reloads cnt = max(alto,1) - 1 (pulse extended, retriggerable one-shot); it does not set pend and never sets erro. Behaviour in IDLE/LOW unchanged.
- Not defined: req during HIGH follows the pend/erro rules above (non-retriggerable).

## Test plan
- Single pulse: alto=3, baixo=2, req[0] one cycle at edge 10 -> saida[0] high edges 10-12 only, ocupado[0] high edges 10-14, saida[1] stays 0.
- Queued request: alto=3, baixo=2, req[0] at edge 10 and 11 -> second pulse rises after edge 15, high 3 cycles; erro[0]=0.
- Overflow: same setup, req[0] at edges 10, 11, 12 -> two pulses only, erro[0]=1 from edge 12 until rst.
- Zero fields: alto=0, baixo=0, req[1] at edges 5 and 6 -> saida[1] high continuously edges 5-6, low after edge 7.
- Reset mid-pulse: alto=8, req[0] at edge 3, rst asserted between edges 5 and 6 -> saida[0], ocupado[0], erro[0] drop immediately; no pulse after rst release without new req.
- Retrigger (GERADOR_RETRIGGER_EN): alto=4, req[0] at edges 10 and 12 -> saida[0] high edges 10-15 (6 cycles), erro[0]=0; without macro, second pulse after gap instead.

Source files
------------

// File: rtl/gerador_borda.sv
// gerador_borda: multi-channel pulse generator.
//
// Each channel turns a single-cycle request strobe into an output pulse that
// is high for max(alto,1) cycles and is then held low for at least baixo
// cycles. While a pulse is in flight, one further request per channel can be
// queued. A request that finds the queue already full is dropped and sets a
// sticky error flag.
//
// Optional feature: define GERADOR_RETRIGGER_EN to make the channels
// retriggerable one-shots. In that build a request during the high phase
// reloads the high counter instead of being queued.
//
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous reset, active-high
//   req     per-channel request strobes
//   alto    high duration in cycles (0 is treated as 1), sampled at pulse start
//   baixo   minimum low gap in cycles (0 = no gap), sampled at pulse start
//   saida   per-channel pulse outputs, decoded from registered state only
//   ocupado per-channel busy: channel not idle, or a request is queued
//   erro    per-channel sticky overflow flag
module gerador_borda #(
  parameter int unsigned CANAIS    = 2,
  parameter int unsigned LARGURA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CANAIS-1:0]    req,
  input  logic [LARGURA_W-1:0] alto,
  input  logic [LARGURA_W-1:0] baixo,
  output logic [CANAIS-1:0]    saida,
  output logic [CANAIS-1:0]    ocupado,
  output logic [CANAIS-1:0]    erro
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;

  logic [CANAIS-1:0][1:0]           state_q, state_d;
  logic [CANAIS-1:0][LARGURA_W-1:0] cnt_q, cnt_d;
  logic [CANAIS-1:0][LARGURA_W-1:0] baixo_l_q, baixo_l_d;
  logic [CANAIS-1:0]                pend_q, pend_d;
  logic [CANAIS-1:0]                erro_q, erro_d;

  // Per-channel decisions for the current cycle.
  logic [CANAIS-1:0] inicio;  // a new pulse is loaded on this edge
  logic [CANAIS-1:0] retrig;  // req absorbed by a retrigger reload

  // Counter load for the high phase: max(alto,1) - 1.
  logic [LARGURA_W-1:0] carga_alto;
  assign carga_alto = (alto == '0) ? '0 : alto - LARGURA_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    baixo_l_d = baixo_l_q;
    pend_d    = pend_q;
    erro_d    = erro_q;
    inicio    = '0;
    retrig    = '0;

    for (int i = 0; i < CANAIS; i++) begin
      unique case (state_q[i])
        StIdle: begin
          inicio[i] = req[i] | pend_q[i];
        end
        StHigh: begin
`ifdef GERADOR_RETRIGGER_EN
          retrig[i] = req[i];
`endif
          if (retrig[i]) begin
            cnt_d[i] = carga_alto;
          end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - LARGURA_W'(1);
          end else if (baixo_l_q[i] != '0) begin
            state_d[i] = StLow;
            cnt_d[i]   = baixo_l_q[i] - LARGURA_W'(1);
          end else if (req[i] | pend_q[i]) begin
            inicio[i] = 1'b1;
          end else begin
            state_d[i] = StIdle;
          end
        end
        StLow: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - LARGURA_W'(1);
          end else if (req[i] | pend_q[i]) begin
            inicio[i] = 1'b1;
          end else begin
            state_d[i] = StIdle;
          end
        end
        default: begin
          state_d[i] = StIdle;
        end
      endcase

      if (inicio[i]) begin
        state_d[i]   = StHigh;
        cnt_d[i]     = carga_alto;
        baixo_l_d[i] = baixo;
        // If the queued request started this pulse, a simultaneous req takes
        // its place in the queue; if req itself started it, nothing is queued.
        pend_d[i]    = pend_q[i] & req[i];
      end else if (req[i] && !retrig[i]) begin
        if (!pend_q[i]) begin
          pend_d[i] = 1'b1;
        end else begin
          erro_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      cnt_q     <= '0;
      baixo_l_q <= '0;
      pend_q    <= '0;
      erro_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      baixo_l_q <= baixo_l_d;
      pend_q    <= pend_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    saida   = '0;
    ocupado = '0;
    for (int i = 0; i < CANAIS; i++) begin
      saida[i]   = (state_q[i] == StHigh);
      ocupado[i] = (state_q[i] != StIdle) | pend_q[i];
    end
  end

  assign erro = erro_q;

endmodule

// File: tb/tb_gerador_borda.sv
// Testbench for gerador_borda. Directed scenarios push the expected rising and
// falling edges of saida (cycle number + polarity) into per-channel queues; a
// monitor detects every change of saida and pops/compares. Status outputs
// (ocupado, erro) are checked directly at chosen cycles.
module tb_gerador_borda;

  localparam int CANAIS    = 2;
  localparam int LARGURA_W = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [CANAIS-1:0]    req = '0;
  logic [LARGURA_W-1:0] alto = '0;
  logic [LARGURA_W-1:0] baixo = '0;
  logic [CANAIS-1:0]    saida;
  logic [CANAIS-1:0]    ocupado;
  logic [CANAIS-1:0]    erro;

  gerador_borda #(
    .CANAIS    (CANAIS),
    .LARGURA_W (LARGURA_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .alto    (alto),
    .baixo   (baixo),
    .saida   (saida),
    .ocupado (ocupado),
    .erro    (erro)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int base  = 0;

  typedef struct {
    int ciclo;
    bit sobe;
  } ev_t;

  ev_t fila0[$];
  ev_t fila1[$];

  task automatic verifica(input string nome, input int atual, input int esperado);
    n_cmp++;
    if (atual != esperado) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, atual, esperado, cyc - base);
    end
  endtask

  // Expected saida edge on channel ch, relative edge number n.
  task automatic espera_ev(input int ch, input int n, input bit sobe);
    ev_t e;
    e.ciclo = base + n;
    e.sobe  = sobe;
    if (ch == 0) fila0.push_back(e);
    else fila1.push_back(e);
  endtask

  task automatic confere_evento(input int ch, input bit valor);
    ev_t e;
    int  vazia;
    vazia = (ch == 0) ? (fila0.size() == 0) : (fila1.size() == 0);
    n_cmp++;
    if (vazia != 0) begin
      n_err++;
      $display("FAIL saida[%0d] unexpected edge: got %0d at cycle %0d, expected no change",
               ch, valor, cyc - base);
    end else begin
      e = (ch == 0) ? fila0.pop_front() : fila1.pop_front();
      if (e.ciclo != cyc || e.sobe != valor) begin
        n_err++;
        $display("FAIL saida[%0d] edge: got level %0d at cycle %0d, expected level %0d at %0d",
                 ch, valor, cyc - base, e.sobe, e.ciclo - base);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [CANAIS-1:0] saida_ant = '0;
  always @(negedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < CANAIS; ch++) begin
        if (saida[ch] !== saida_ant[ch]) confere_evento(ch, saida[ch]);
      end
    end
    saida_ant = saida;
  end

  // At a negedge where the state reflects edge base+n.
  task automatic apos(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  // Drive req mask so it is sampled at edge base+n, then release.
  task automatic pede(input logic [CANAIS-1:0] m, input int n);
    apos(n - 1);
    req = m;
    @(negedge clk);
    req = '0;
  endtask

  task automatic reinicia();
    @(negedge clk);
    #2 rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    base = cyc;
  endtask

  task automatic fim_teste(input string nome);
    apos(30);
    verifica({nome, " fila0 drained"}, fila0.size(), 0);
    verifica({nome, " fila1 drained"}, fila1.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reinicia();
    verifica("reset saida", int'(saida), 0);
    verifica("reset ocupado", int'(ocupado), 0);
    verifica("reset erro", int'(erro), 0);

    // Single pulse
    alto = 8'd3; baixo = 8'd2;
    espera_ev(0, 10, 1); espera_ev(0, 13, 0);
    pede(2'b01, 10);
    apos(11); verifica("single saida[1]", int'(saida[1]), 0);
    apos(14); verifica("single ocupado[0]@14", int'(ocupado[0]), 1);
    apos(15); verifica("single ocupado[0]@15", int'(ocupado[0]), 0);
    verifica("single erro", int'(erro), 0);
    fim_teste("single");

    // Queued request
    reinicia();
    espera_ev(0, 10, 1); espera_ev(0, 13, 0);
    espera_ev(0, 15, 1); espera_ev(0, 18, 0);
    pede(2'b01, 10); pede(2'b01, 11);
    apos(20); verifica("queued erro[0]", int'(erro[0]), 0);
    verifica("queued ocupado[0]@20", int'(ocupado[0]), 0);
    fim_teste("queued");

    // Overflow
    reinicia();
    espera_ev(0, 10, 1); espera_ev(0, 13, 0);
    espera_ev(0, 15, 1); espera_ev(0, 18, 0);
    pede(2'b01, 10); pede(2'b01, 11);
    verifica("overflow erro@11", int'(erro[0]), 0);
    pede(2'b01, 12);
    verifica("overflow erro@12", int'(erro[0]), 1);
    apos(25); verifica("overflow erro sticky", int'(erro[0]), 1);
    verifica("overflow ocupado[0]@25", int'(ocupado[0]), 0);
    fim_teste("overflow");

    // Zero fields, channel 1, back-to-back
    reinicia();
    verifica("reset clears erro", int'(erro), 0);
    alto = 8'd0; baixo = 8'd0;
    espera_ev(1, 5, 1); espera_ev(1, 7, 0);
    pede(2'b10, 5); pede(2'b10, 6);
    apos(7); verifica("zero ocupado[1]@7", int'(ocupado[1]), 0);
    fim_teste("zero");

    // Back-to-back queued pulse with baixo=0
    reinicia();
    alto = 8'd2; baixo = 8'd0;
    espera_ev(0, 3, 1);
`ifdef GERADOR_RETRIGGER_EN
    espera_ev(0, 6, 0);
`else
    espera_ev(0, 7, 0);
`endif
    pede(2'b01, 3); pede(2'b01, 4);
    fim_teste("b2b");

    // Simultaneous channels; alto change mid-pulse must not matter
    reinicia();
    alto = 8'd2; baixo = 8'd1;
    espera_ev(0, 4, 1); espera_ev(0, 6, 0);
    espera_ev(1, 4, 1); espera_ev(1, 6, 0);
    pede(2'b11, 4);
    alto = 8'd7;
    apos(6); verifica("simul ocupado@6", int'(ocupado), 3);
    apos(7); verifica("simul ocupado@7", int'(ocupado), 0);
    fim_teste("simul");

    // Retrigger vs. queued
    reinicia();
    alto = 8'd4; baixo = 8'd2;
    espera_ev(0, 10, 1);
`ifdef GERADOR_RETRIGGER_EN
    espera_ev(0, 16, 0);
`else
    espera_ev(0, 14, 0); espera_ev(0, 16, 1); espera_ev(0, 20, 0);
`endif
    pede(2'b01, 10); pede(2'b01, 12);
    apos(22); verifica("retrig erro", int'(erro[0]), 0);
    fim_teste("retrig");

    // Reset mid-pulse, with erro set beforehand
    reinicia();
    alto = 8'd8; baixo = 8'd0;
    espera_ev(0, 3, 1);
    pede(2'b01, 3); pede(2'b01, 4); pede(2'b01, 5);
    verifica("rstmid erro before", int'(erro[0]), 1);
    #2 rst = 1'b1;
    #1;
    verifica("rstmid saida", int'(saida[0]), 0);
    verifica("rstmid ocupado", int'(ocupado[0]), 0);
    verifica("rstmid erro", int'(erro[0]), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    apos(20);
    verifica("rstmid idle ocupado", int'(ocupado), 0);
    verifica("rstmid idle saida", int'(saida), 0);
    fim_teste("rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
